// File: rtl/mem_access_stage_if.sv
// Data-cache request/response bus between the MEM stage and the dcache.
// The master drives a request and holds it; the slave answers with dhit.
interface mem_access_stage_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;

    modport master (
        output dmemREN,
        output dmemWEN,
        output dmemaddr,
        output dmemstore,
        input  dhit,
        input  dmemload
    );

    modport slave (
        input  dmemREN,
        input  dmemWEN,
        input  dmemaddr,
        input  dmemstore,
        output dhit,
        output dmemload
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller. Sits between the EX/MEM and
// MEM/WB latches, holds each dcache request until dhit while stalling the
// front of the pipe, keeps the LL/SC link register, and registers exactly
// one result per accepted instruction for MEM/WB.
module mem_access_stage #(
    parameter int TAG_W = 16,
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ex_valid,
    input  logic              ex_ren,
    input  logic              ex_wen,
    input  logic              ex_ll,
    input  logic              ex_sc,
    input  logic              ex_halt,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_store,
    input  logic [TAG_W-1:0]  ex_tag,
    input  logic              inv_valid,
    input  logic [31:0]       inv_addr,
    mem_access_stage_if.master dcache,
    output logic              mem_stall,
    output logic              mem_valid,
    output logic [31:0]       mem_data,
    output logic [TAG_W-1:0]  mem_tag,
    output logic              mem_halt,
    output logic              link_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Request captured at accept time and held stable for the whole access.
    logic [31:0]       addr_p0;
    logic [31:0]       store_p0;
    logic [TAG_W-1:0]  tag_p0;
    logic              ren_p0;
    logic              wen_p0;
    logic              ll_p0;
    logic              sc_p0;

    // Link register keeps only the word address; byte offset is irrelevant.
    logic [29:0]       link_word;

    logic              start_access;
    logic              done_direct;
    logic              done_halt;
    logic              done_access;
    logic [31:0]       direct_data;
    logic [31:0]       access_data;

    logic              sc_link_hit;
    logic              inv_link_hit;
    logic              inv_new_hit;
    logic              sw_link_hit;
    logic              unused_inv_lo;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    assign sc_link_hit   = link_valid && (link_word == ex_addr[31:2]);
    assign inv_link_hit  = inv_valid && (inv_addr[31:2] == link_word);
    assign inv_new_hit   = inv_valid && (inv_addr[31:2] == addr_p0[31:2]);
    assign sw_link_hit   = (link_word == addr_p0[31:2]);
    assign unused_inv_lo = ^inv_addr[1:0];

    assign dcache.dmemaddr  = addr_p0;
    assign dcache.dmemstore = store_p0;

    assign access_data = ren_p0 ? dcache.dmemload :
                         sc_p0  ? 32'd1 : addr_p0;

    // State register; reset aborts any access in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state, request strobes and stall; halt outranks any memory op.
    always_comb begin
        state_nxt      = state;
        start_access   = 1'b0;
        done_direct    = 1'b0;
        done_halt      = 1'b0;
        done_access    = 1'b0;
        direct_data    = ex_addr;
        mem_stall      = 1'b0;
        dcache.dmemREN = 1'b0;
        dcache.dmemWEN = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_halt) begin
                        done_halt = 1'b1;
                        state_nxt = HALTED;
                    end else if (ex_sc && !sc_link_hit) begin
                        done_direct = 1'b1;
                        direct_data = 32'd0;
                    end else if (ex_ren || ex_wen || ex_ll || ex_sc) begin
                        start_access = 1'b1;
                        state_nxt    = ACCESS;
                    end else begin
                        done_direct = 1'b1;
                    end
                end
            end
            ACCESS: begin
                mem_stall      = 1'b1;
                dcache.dmemREN = ren_p0;
                dcache.dmemWEN = wen_p0;
                if (dcache.dhit) begin
                    done_access = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            HALTED: begin
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request when an access is started.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_p0  <= '0;
            store_p0 <= '0;
            tag_p0   <= '0;
            ren_p0   <= 1'b0;
            wen_p0   <= 1'b0;
            ll_p0    <= 1'b0;
            sc_p0    <= 1'b0;
        end else if (start_access) begin
            addr_p0  <= ex_addr;
            store_p0 <= ex_store;
            tag_p0   <= ex_tag;
            ren_p0   <= ex_ren || ex_ll;
            wen_p0   <= ex_wen || ex_sc;
            ll_p0    <= ex_ll;
            sc_p0    <= ex_sc;
        end
    end

    // MEM/WB result: single-cycle valid pulse, payload held until next completion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_valid <= 1'b0;
            mem_data  <= '0;
            mem_tag   <= '0;
            mem_halt  <= 1'b0;
        end else begin
            mem_valid <= 1'b0;
            if (done_halt) begin
                mem_valid <= 1'b1;
                mem_halt  <= 1'b1;
                mem_data  <= ex_addr;
                mem_tag   <= ex_tag;
            end else if (done_direct) begin
                mem_valid <= 1'b1;
                mem_halt  <= 1'b0;
                mem_data  <= direct_data;
                mem_tag   <= ex_tag;
            end else if (done_access) begin
                mem_valid <= 1'b1;
                mem_halt  <= 1'b0;
                mem_data  <= access_data;
                mem_tag   <= tag_p0;
            end
        end
    end

    // Link register; a snoop to the word being linked beats the LL itself.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_word  <= '0;
        end else if (done_halt) begin
            link_valid <= 1'b0;
        end else if (done_access && ll_p0) begin
            link_word  <= addr_p0[31:2];
            link_valid <= !inv_new_hit;
        end else if ((done_access && (sc_p0 || (wen_p0 && sw_link_hit))) || inv_link_hit) begin
            link_valid <= 1'b0;
        end
    end

    // Saturating count of cycles spent waiting on the dcache.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                 stall_cnt <= '0;
        else if (state == ACCESS) stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// randomized traffic, checked against a transaction-level model of the link
// register, stall counter and expected MEM/WB results.
module tb_mem_access_stage;
    localparam int TAG_W = 16;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int K_ALU  = 0;
    localparam int K_LW   = 1;
    localparam int K_SW   = 2;
    localparam int K_LL   = 3;
    localparam int K_SC   = 4;
    localparam int K_HALT = 5;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             ex_valid = 1'b0;
    logic             ex_ren = 1'b0;
    logic             ex_wen = 1'b0;
    logic             ex_ll = 1'b0;
    logic             ex_sc = 1'b0;
    logic             ex_halt = 1'b0;
    logic [31:0]      ex_addr = '0;
    logic [31:0]      ex_store = '0;
    logic [TAG_W-1:0] ex_tag = '0;
    logic             inv_valid = 1'b0;
    logic [31:0]      inv_addr = '0;
    logic             mem_stall;
    logic             mem_valid;
    logic [31:0]      mem_data;
    logic [TAG_W-1:0] mem_tag;
    logic             mem_halt;
    logic             link_valid;
    logic [CNT_W-1:0] stall_cnt;

    mem_access_stage_if dif();

    mem_access_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ex_valid   (ex_valid),
        .ex_ren     (ex_ren),
        .ex_wen     (ex_wen),
        .ex_ll      (ex_ll),
        .ex_sc      (ex_sc),
        .ex_halt    (ex_halt),
        .ex_addr    (ex_addr),
        .ex_store   (ex_store),
        .ex_tag     (ex_tag),
        .inv_valid  (inv_valid),
        .inv_addr   (inv_addr),
        .dcache     (dif),
        .mem_stall  (mem_stall),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .mem_tag    (mem_tag),
        .mem_halt   (mem_halt),
        .link_valid (link_valid),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        bit               halt;
    } res_t;

    res_t        exp_q[$];
    bit          link_v_m = 1'b0;
    logic [31:0] link_a_m = '0;
    int          cnt_m = 0;
    bit          halted_m = 1'b0;

    // Result checker: every valid pulse must match the oldest expected result,
    // and between pulses the payload must hold.
    res_t             cur_e;
    logic [31:0]      last_data = '0;
    logic [TAG_W-1:0] last_tag = '0;
    bit               last_chk = 1'b1;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                last_data = '0;
                last_tag  = '0;
                last_chk  = 1'b1;
            end else if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_mem_valid", 32'(mem_valid), 32'd0);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk("mem_halt", 32'(mem_halt), 32'(cur_e.halt));
                    if (!cur_e.halt) begin
                        chk("mem_data", mem_data, cur_e.data);
                        chk("mem_tag", 32'(mem_tag), 32'(cur_e.tag));
                        last_data = cur_e.data;
                        last_tag  = cur_e.tag;
                        last_chk  = 1'b1;
                    end else begin
                        last_chk = 1'b0;
                    end
                end
            end else if (last_chk) begin
                chk("hold_data", mem_data, last_data);
                chk("hold_tag", 32'(mem_tag), 32'(last_tag));
            end
        end
    end

    function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    // Present one instruction in IDLE (or HALTED), play the dcache for lat
    // cycles, and update the model. inv_mode: 0 none, 1 snoop op address,
    // 2 snoop link address, 3 snoop random address, all on the dhit cycle.
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] store,
                          input logic [TAG_W-1:0] tag, input int lat,
                          input logic [31:0] load, input int inv_mode);
        bit          acc;
        bit          rd;
        bit          wr;
        bit          iv;
        logic [31:0] ia;
        res_t        e;
        acc = 1'b0;
        iv  = 1'b0;
        ia  = '0;
        rd  = (kind == K_LW) || (kind == K_LL);
        wr  = (kind == K_SW) || (kind == K_SC);
        chk("idle_stall", 32'(mem_stall), 32'd0);
        chk("idle_ren", 32'(dif.dmemREN), 32'd0);
        chk("idle_wen", 32'(dif.dmemWEN), 32'd0);
        ex_valid = 1'b1;
        ex_halt  = (kind == K_HALT);
        ex_ren   = rd || (kind == K_HALT);
        ex_wen   = wr;
        ex_ll    = (kind == K_LL);
        ex_sc    = (kind == K_SC);
        ex_addr  = addr;
        ex_store = store;
        ex_tag   = tag;
        if (!halted_m) begin
            case (kind)
                K_HALT: begin
                    e.data = addr; e.tag = tag; e.halt = 1'b1;
                    exp_q.push_back(e);
                    link_v_m = 1'b0;
                    halted_m = 1'b1;
                end
                K_ALU: begin
                    e.data = addr; e.tag = tag; e.halt = 1'b0;
                    exp_q.push_back(e);
                end
                K_SC: begin
                    if (link_v_m && same_word(link_a_m, addr)) acc = 1'b1;
                    else begin
                        e.data = 32'd0; e.tag = tag; e.halt = 1'b0;
                        exp_q.push_back(e);
                    end
                end
                default: acc = 1'b1;
            endcase
        end
        @(negedge CLK);
        ex_valid = 1'b0;
        ex_addr  = $urandom;
        ex_store = $urandom;
        ex_tag   = TAG_W'($urandom);
        if (acc) begin
            for (int k = 1; k <= lat; k++) begin
                chk("acc_ren", 32'(dif.dmemREN), 32'(rd));
                chk("acc_wen", 32'(dif.dmemWEN), 32'(wr));
                chk("acc_addr", dif.dmemaddr, addr);
                chk("acc_store", dif.dmemstore, store);
                chk("acc_stall", 32'(mem_stall), 32'd1);
                if (k == lat) begin
                    dif.dhit     = 1'b1;
                    dif.dmemload = load;
                    case (inv_mode)
                        1: begin iv = 1'b1; ia = addr; end
                        2: begin iv = 1'b1; ia = link_a_m; end
                        3: begin iv = 1'b1; ia = $urandom; end
                        default: iv = 1'b0;
                    endcase
                    inv_valid = iv;
                    inv_addr  = ia;
                    e.tag  = tag;
                    e.halt = 1'b0;
                    case (kind)
                        K_SW:    e.data = addr;
                        K_SC:    e.data = 32'd1;
                        default: e.data = load;
                    endcase
                    exp_q.push_back(e);
                    if (kind == K_LL) begin
                        link_a_m = addr;
                        link_v_m = !(iv && same_word(ia, addr));
                    end else begin
                        if (kind == K_SC) link_v_m = 1'b0;
                        if (kind == K_SW && same_word(addr, link_a_m)) link_v_m = 1'b0;
                        if (iv && same_word(ia, link_a_m)) link_v_m = 1'b0;
                    end
                end else begin
                    dif.dhit     = 1'b0;
                    dif.dmemload = $urandom;
                end
                @(negedge CLK);
            end
            dif.dhit  = 1'b0;
            inv_valid = 1'b0;
            cnt_m = (cnt_m + lat > CNT_MAX) ? CNT_MAX : cnt_m + lat;
        end else begin
            chk("noacc_ren", 32'(dif.dmemREN), 32'd0);
            chk("noacc_wen", 32'(dif.dmemWEN), 32'd0);
            chk("noacc_stall", 32'(mem_stall), 32'd0);
        end
        chk("link_valid", 32'(link_valid), 32'(link_v_m));
        chk("stall_cnt", 32'(stall_cnt), 32'(cnt_m));
    endtask

    // One-cycle snoop while no instruction is presented.
    task automatic inv_pulse(input logic [31:0] a);
        inv_valid = 1'b1;
        inv_addr  = a;
        if (same_word(a, link_a_m)) link_v_m = 1'b0;
        @(negedge CLK);
        inv_valid = 1'b0;
        chk("inv_link_valid", 32'(link_valid), 32'(link_v_m));
    endtask

    logic [31:0] pool [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        int          r;
        logic [31:0] a;
        pool[0] = 32'h0000_0200;
        pool[1] = 32'h0000_0204;
        pool[2] = 32'h0000_1000;
        pool[3] = 32'h8000_7FFC;
        dif.dhit     = 1'b0;
        dif.dmemload = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ren", 32'(dif.dmemREN), 32'd0);
        chk("rst_wen", 32'(dif.dmemWEN), 32'd0);
        chk("rst_addr", dif.dmemaddr, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_link", 32'(link_valid), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // Reset asserted in the middle of an access
        ex_valid = 1'b1; ex_ren = 1'b1; ex_wen = 1'b0; ex_ll = 1'b0; ex_sc = 1'b0;
        ex_halt = 1'b0; ex_addr = 32'h300; ex_tag = 16'h0033;
        @(negedge CLK);
        ex_valid = 1'b0;
        chk("pre_rst_ren", 32'(dif.dmemREN), 32'd1);
        @(negedge CLK);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("rst_drop_ren", 32'(dif.dmemREN), 32'd0);
        chk("rst_drop_stall", 32'(mem_stall), 32'd0);
        exp_q.delete();
        link_v_m = 1'b0; link_a_m = '0; cnt_m = 0; halted_m = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rel_cnt", 32'(stall_cnt), 32'd0);
        chk("rel_valid", 32'(mem_valid), 32'd0);
        chk("rel_ren", 32'(dif.dmemREN), 32'd0);

        // ALU pass-through
        run_op(K_ALU, 32'h0000_00A4, 32'h0, 16'h00A4, 1, 32'h0, 0);
        chk("alu_lit_data", mem_data, 32'h0000_00A4);

        // lw with three-cycle dcache latency
        run_op(K_LW, 32'h100, 32'h0, 16'h0100, 3, 32'hDEAD_BEEF, 0);
        chk("lw_lit_data", mem_data, 32'hDEAD_BEEF);
        chk("lw_lit_cnt", 32'(stall_cnt), 32'd3);

        // ll then successful sc
        run_op(K_LL, 32'h200, 32'h0, 16'h0201, 2, 32'h1234_5678, 0);
        chk("ll_lit_link", 32'(link_valid), 32'd1);
        run_op(K_SC, 32'h200, 32'h5, 16'h0202, 2, 32'h0, 0);
        chk("sc_lit_data", mem_data, 32'd1);
        chk("sc_lit_link", 32'(link_valid), 32'd0);

        // ll, snoop to the linked word, sc fails without touching memory
        run_op(K_LL, 32'h200, 32'h0, 16'h0203, 1, 32'hCAFE_0000, 0);
        inv_pulse(32'h200);
        run_op(K_SC, 32'h200, 32'h7, 16'h0204, 1, 32'h0, 0);
        chk("scmiss_lit_data", mem_data, 32'd0);

        // snoop in the same cycle as ll dhit to that word wins
        run_op(K_LL, 32'h204, 32'h0, 16'h0205, 2, 32'h0BAD_F00D, 1);
        chk("llinv_lit_link", 32'(link_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 15) kind = K_ALU;
            else if (r < 40) kind = K_LW;
            else if (r < 60) kind = K_SW;
            else if (r < 80) kind = K_LL;
            else             kind = K_SC;
            a = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            run_op(kind, a, $urandom, TAG_W'($urandom), $urandom_range(1, 4), $urandom,
                   (r < 6) ? 0 : $urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0)
                inv_pulse(pool[$urandom_range(0, 3)]);
        end
        chk("sat_lit_cnt", 32'(stall_cnt), 32'(CNT_MAX));

        // Halt, then everything afterwards is ignored
        run_op(K_LL, 32'h1000, 32'h0, 16'h0300, 1, 32'h1, 0);
        run_op(K_HALT, 32'h0000_0FFF, 32'h0, 16'h0FFF, 1, 32'h0, 0);
        chk("halt_lit_flag", 32'(mem_halt), 32'd1);
        chk("halt_lit_link", 32'(link_valid), 32'd0);
        for (int i = 0; i < 6; i++)
            run_op(K_LW + (i % 4), pool[i % 4], $urandom, TAG_W'($urandom), 1, $urandom, 0);
        repeat (3) @(negedge CLK);
        chk("halt_no_ren", 32'(dif.dmemREN), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
